// File: rtl/if_fetch_queue_if.sv
// Bundle of the fetch queue's ROM-side and decode-side signals.
// master: the fetch queue itself. slave: the ROM model and decode stage around it.
interface if_fetch_queue_if #(
  parameter int AW = 2
);

  // ROM side
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;

  // Redirect from downstream
  logic        flush_i;
  logic [31:0] flush_pc_i;

  // Decode side
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        id_ready_i;

  // Status and performance counters
  logic [AW:0] count_o;
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_flush_o;

  modport master (
    output rom_ce_o,
    output rom_addr_o,
    input  rom_data_i,
    input  flush_i,
    input  flush_pc_i,
    output inst_valid_o,
    output inst_o,
    output pc_o,
    input  id_ready_i,
    output count_o,
    output perf_fetch_o,
    output perf_flush_o
  );

  modport slave (
    input  rom_ce_o,
    input  rom_addr_o,
    output rom_data_i,
    output flush_i,
    output flush_pc_i,
    input  inst_valid_o,
    input  inst_o,
    input  pc_o,
    output id_ready_i,
    input  count_o,
    input  perf_fetch_o,
    input  perf_flush_o
  );

endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between the instruction ROM and decode.
// Owns the fetch PC, reads one instruction per cycle from a combinational ROM and
// buffers {pc, inst} pairs in a first-word-fall-through FIFO drained by a
// valid/ready handshake. A flush discards the queue and restarts fetch at a new PC.
// Optional feature macro: IFQ_PERF_EN enables push and flush event counters;
// without it perf_fetch_o/perf_flush_o read as zero.
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst,    // synchronous, active-low
  if_fetch_queue_if.master bus
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Queue state
  logic [31:0]   fetch_pc;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];

  // Handshake terms
  logic        active;
  logic        full;
  logic        head_valid;
  logic        push;
  logic        pop;
  logic [AW:0] count_next;
  logic [31:0] flush_target;

  // Handshake and occupancy decode; a flush or reset blocks both push and pop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    active       = 1'b0;
    full         = 1'b0;
    head_valid   = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    count_next   = count;
    flush_target = bus.flush_pc_i & ~32'h0000_0003;

    active     = rst & ~bus.flush_i;
    full       = (count == DEPTH_C);
    head_valid = active & (count != '0);
    pop        = head_valid & bus.id_ready_i;
    // A full queue may still fetch when the head leaves in the same cycle.
    push       = active & (~full | pop);

    unique case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Control state: fetch PC, pointers and occupancy, with reset above flush.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (bus.flush_i) begin
      fetch_pc <= flush_target;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_next;
    end
  end

  // Entry storage: writes the fetched pair into the tail slot.
  always_ff @(posedge clk) begin
    // NOTE: the entry array carries no reset; count and the pointers decide
    // which slots are meaningful, so stale contents are never presented as valid.
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      inst_mem[wr_ptr] <= bus.rom_data_i;
    end
  end

  // Outputs: the ROM address is the fetch PC; the head is read through (FWFT).
  assign bus.rom_ce_o     = push;
  assign bus.rom_addr_o   = fetch_pc;
  assign bus.inst_valid_o = head_valid;
  assign bus.inst_o       = inst_mem[rd_ptr];
  assign bus.pc_o         = pc_mem[rd_ptr];
  assign bus.count_o      = count;

`ifdef IFQ_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_flush;

  // Event counters: pushes and flush cycles, cleared only by reset, free-wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetch <= '0;
      perf_flush <= '0;
    end else begin
      if (push) begin
        perf_fetch <= perf_fetch + 32'd1;
      end
      if (bus.flush_i) begin
        perf_flush <= perf_flush + 32'd1;
      end
    end
  end

  assign bus.perf_fetch_o = perf_fetch;
  assign bus.perf_flush_o = perf_flush;
`else
  assign bus.perf_fetch_o = 32'h0;
  assign bus.perf_flush_o = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: a table of per-cycle vectors for the
// streaming, backpressure and flush behaviour, followed by hand-written
// sequences for back-to-back flushes, reset during flush, PC wrap and counters.
module tb_if_fetch_queue;

  logic clk;
  logic rst;

  if_fetch_queue_if #(.AW(2)) bus ();

  if_fetch_queue #(
    .DEPTH    (4),
    .AW       (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational ROM model: word i holds i + 0x100.
  assign bus.rom_data_i = (bus.rom_addr_o >> 2) + 32'h100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst_v;
    logic        flush;
    logic [31:0] fpc;
    logic        rdy;
    logic        valid;
    logic        ce;
    logic [2:0]  cnt;
    logic [31:0] addr;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  function automatic vec_t mk(input logic r, input logic f, input logic [31:0] fp,
                              input logic rd, input logic v, input logic c,
                              input logic [2:0] n, input logic [31:0] a,
                              input logic [31:0] p);
    vec_t t;
    t.rst_v = r; t.flush = f; t.fpc = fp; t.rdy = rd;
    t.valid = v; t.ce = c; t.cnt = n; t.addr = a; t.pc = p;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic [31:0] fp, input logic rd);
    rst            = r;
    bus.flush_i    = f;
    bus.flush_pc_i = fp;
    bus.id_ready_i = rd;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Compare the current-cycle outputs; head contents only matter when valid.
  task automatic expect_out(input string tag, input logic v, input logic c,
                            input logic [2:0] n, input logic [31:0] a, input logic [31:0] p);
    check({tag, " valid"}, {31'b0, bus.inst_valid_o}, {31'b0, v});
    check({tag, " rom_ce"}, {31'b0, bus.rom_ce_o}, {31'b0, c});
    check({tag, " count"}, {29'b0, bus.count_o}, {29'b0, n});
    check({tag, " rom_addr"}, bus.rom_addr_o, a);
    if (v) begin
      check({tag, " pc"}, bus.pc_o, p);
      check({tag, " inst"}, bus.inst_o, rom_word(p));
    end
  endtask

  initial begin
    logic [31:0] exp_pf;
    logic [31:0] exp_pl;

    // Streaming with decode always ready, then a reset.
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 32'h00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 32'h04, 32'h00));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 32'h08, 32'h04));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 32'h0C, 32'h08));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 32'h10, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h00, 0));
    // Backpressure for 10 cycles: fill to 4, then fetch stalls at 0x10.
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'h00, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 1, 32'h04, 32'h00));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 2, 32'h08, 32'h00));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 3, 32'h0C, 32'h00));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(1, 0, 0, 0, 1, 0, 4, 32'h10, 32'h00));
    // Full and ready: push and pop every cycle, in-order drain with no gap.
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 4, 32'h10, 32'h00));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 4, 32'h14, 32'h04));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 4, 32'h18, 32'h08));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 4, 32'h1C, 32'h0C));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 4, 32'h20, 32'h10));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 4, 32'h24, 32'h14));
    // Reset, fill to 3, flush to 0x43 (low bits dropped).
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 4, 32'h28, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h00, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'h00, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 1, 32'h04, 32'h00));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 2, 32'h08, 32'h00));
    vecs.push_back(mk(1, 1, 32'h43, 0, 0, 0, 3, 32'h0C, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 1, 0, 32'h40, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 32'h44, 32'h40));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 32'h48, 32'h44));

    // Initial reset: two edges with rst low.
    drive(0, 0, 0, 1);
    next_cycle();
    next_cycle();

    foreach (vecs[i]) begin
      drive(vecs[i].rst_v, vecs[i].flush, vecs[i].fpc, vecs[i].rdy);
      expect_out($sformatf("vec%0d", i), vecs[i].valid, vecs[i].ce, vecs[i].cnt,
                 vecs[i].addr, vecs[i].pc);
      next_cycle();
    end

    // Back-to-back flushes: the second target wins.
    drive(1, 1, 32'h80, 1);
    expect_out("flushA", 0, 0, 1, 32'h4C, 0);
    next_cycle();
    drive(1, 1, 32'h200, 1);
    expect_out("flushB", 0, 0, 0, 32'h80, 0);
    next_cycle();
    drive(1, 0, 0, 1);
    expect_out("flushC", 0, 1, 0, 32'h200, 0);
    next_cycle();
    expect_out("flushD", 1, 1, 1, 32'h204, 32'h200);
    next_cycle();

    // Reset coinciding with flush: reset wins, fetch restarts at RESET_PC.
    drive(0, 1, 32'h300, 1);
    expect_out("rstflushA", 0, 0, 1, 32'h208, 0);
    next_cycle();
    drive(0, 0, 0, 1);
    expect_out("rstflushB", 0, 0, 0, 32'h0, 0);
    next_cycle();

    // PC wrap: flush to the top word, fetch continues at address 0.
    drive(1, 1, 32'hFFFF_FFFF, 1);
    expect_out("wrapA", 0, 0, 0, 32'h0, 0);
    next_cycle();
    drive(1, 0, 0, 1);
    expect_out("wrapB", 0, 1, 0, 32'hFFFF_FFFC, 0);
    next_cycle();
    expect_out("wrapC", 1, 1, 1, 32'h0, 32'hFFFF_FFFC);
    next_cycle();
    expect_out("wrapD", 1, 1, 1, 32'h4, 32'h0);
    next_cycle();

    // Counters: reset clears them, then 7 pushes and 2 flush cycles.
    drive(0, 0, 0, 1);
    next_cycle();
    check("perf_fetch after reset", bus.perf_fetch_o, 32'h0);
    check("perf_flush after reset", bus.perf_flush_o, 32'h0);
    next_cycle();
    drive(1, 0, 0, 1);
    for (int i = 0; i < 7; i++) next_cycle();
    drive(1, 1, 32'h100, 1);
    next_cycle();
    next_cycle();
    drive(1, 0, 0, 1);
`ifdef IFQ_PERF_EN
    exp_pf = 32'd7;
    exp_pl = 32'd2;
`else
    exp_pf = 32'd0;
    exp_pl = 32'd0;
`endif
    check("perf_fetch", bus.perf_fetch_o, exp_pf);
    check("perf_flush", bus.perf_flush_o, exp_pl);
    check("post-flush fetch addr", bus.rom_addr_o, 32'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
